// File: rtl/key_search_coordinator.sv
// Coordinates a pool of brute-force decryptor cores: launches them, watches for
// a verified key, exhaustion or abort, and latches the winning key and core index.
module key_search_coordinator #(
  parameter int CORE_COUNT = 128,
  parameter int KEY_WIDTH  = 22,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                                             i_clk,
  input  logic                                             i_reset,
  input  logic                                             i_start,
  input  logic                                             i_abort,
  input  logic [CORE_COUNT-1:0]                            i_core_found,
  input  logic [CORE_COUNT-1:0]                            i_core_busy,
  input  logic [CORE_COUNT*KEY_WIDTH-1:0]                  i_core_key,
  output logic                                             o_core_start,
  output logic                                             o_stop_all,
  output logic                                             o_found,
  output logic                                             o_exhausted,
  output logic                                             o_aborted,
  output logic                                             o_busy,
  output logic [KEY_WIDTH-1:0]                             o_key_out,
  output logic [((CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1)-1:0] o_winner_idx,
  output logic [KEY_WIDTH-1:0]                             o_progress_key,
  output logic [CNT_WIDTH-1:0]                             o_cycle_count
);

  localparam int IDX_W = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_SEARCH,
    S_LATCH,
    S_DONE
  } state_t;

  state_t               r_state;
  logic                 r_core_start;
  logic                 r_stop_all;
  logic                 r_found;
  logic                 r_exhausted;
  logic                 r_aborted;
  logic                 r_busy;
  logic [KEY_WIDTH-1:0] r_key_out;
  logic [IDX_W-1:0]     r_winner_idx;
  logic [KEY_WIDTH-1:0] r_progress_key;
  logic [CNT_WIDTH-1:0] r_cycle_count;
  logic [1:0]           r_grace;
  logic                 r_rearmed;

  logic [KEY_WIDTH-1:0] w_core_keys [CORE_COUNT];
  logic                 w_any_found;
  logic [IDX_W-1:0]     w_win_idx;
  logic [KEY_WIDTH-1:0] w_win_key;
  logic                 w_all_idle;

  genvar gi;
  generate
    for (gi = 0; gi < CORE_COUNT; gi++) begin : g_key_unpack
      assign w_core_keys[gi] = i_core_key[gi*KEY_WIDTH +: KEY_WIDTH];
    end
  endgenerate

  // Scan from the top down so the lowest-indexed found core is the last write.
  always_comb begin
    w_any_found = 1'b0;
    w_win_idx   = '0;
    w_win_key   = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (i_core_found[i]) begin
        w_any_found = 1'b1;
        w_win_idx   = IDX_W'(i);
        w_win_key   = w_core_keys[i];
      end
    end
  end

  assign w_all_idle = ~|i_core_busy;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_core_start   <= 1'b0;
      r_stop_all     <= 1'b0;
      r_found        <= 1'b0;
      r_exhausted    <= 1'b0;
      r_aborted      <= 1'b0;
      r_busy         <= 1'b0;
      r_key_out      <= '0;
      r_winner_idx   <= '0;
      r_progress_key <= '0;
      r_cycle_count  <= '0;
      r_grace        <= '0;
      r_rearmed      <= 1'b0;
    end else begin
      if (r_busy) r_progress_key <= w_core_keys[0];

      case (r_state)
        S_IDLE, S_DONE: begin
          // A held start must be seen low in DONE before it can relaunch.
          if (r_state == S_DONE && !i_start) r_rearmed <= 1'b1;
          if (i_start && !i_abort && (r_state == S_IDLE || r_rearmed)) begin
            r_state       <= S_LAUNCH;
            r_core_start  <= 1'b1;
            r_busy        <= 1'b1;
            r_stop_all    <= 1'b0;
            r_found       <= 1'b0;
            r_exhausted   <= 1'b0;
            r_aborted     <= 1'b0;
            r_key_out     <= '0;
            r_winner_idx  <= '0;
            r_cycle_count <= '0;
            r_grace       <= '0;
            r_rearmed     <= 1'b0;
          end
        end

        S_LAUNCH: begin
          r_state      <= S_SEARCH;
          r_core_start <= 1'b0;
        end

        S_SEARCH: begin
          if (r_cycle_count != {CNT_WIDTH{1'b1}}) r_cycle_count <= r_cycle_count + CNT_WIDTH'(1);
          if (w_any_found) begin
            r_state      <= S_LATCH;
            r_key_out    <= w_win_key;
            r_winner_idx <= w_win_idx;
            r_stop_all   <= 1'b1;
          end else if (i_abort) begin
            r_state    <= S_DONE;
            r_aborted  <= 1'b1;
            r_stop_all <= 1'b1;
            r_busy     <= 1'b0;
          end else if (r_grace == 2'd2 && w_all_idle) begin
            r_state     <= S_DONE;
            r_exhausted <= 1'b1;
            r_stop_all  <= 1'b1;
            r_busy      <= 1'b0;
          end else if (r_grace != 2'd2) begin
            // Cores may not have raised busy yet in the first two cycles.
            r_grace <= r_grace + 2'd1;
          end
        end

        S_LATCH: begin
          r_state <= S_DONE;
          r_found <= 1'b1;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_core_start <= 1'b0;
          r_stop_all   <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_core_start   = r_core_start;
  assign o_stop_all     = r_stop_all;
  assign o_found        = r_found;
  assign o_exhausted    = r_exhausted;
  assign o_aborted      = r_aborted;
  assign o_busy         = r_busy;
  assign o_key_out      = r_key_out;
  assign o_winner_idx   = r_winner_idx;
  assign o_cycle_count  = r_cycle_count;
  // Live view of core 0 while a search runs; last sampled value afterwards.
  assign o_progress_key = r_busy ? w_core_keys[0] : r_progress_key;

endmodule

// File: tb/tb_key_search_coordinator.sv
// Table-driven bench for key_search_coordinator with a scoreboard of expected
// search outcomes plus hand-written reset, relaunch and abort sequences.
module tb_key_search_coordinator;
  localparam int CC = 4;
  localparam int KW = 22;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CC-1:0]  core_found = '0;
  logic [CC-1:0]  core_busy = '1;
  logic [KW-1:0]  keys [CC];
  logic [CC*KW-1:0] core_key;

  logic           o_core_start, o_stop_all, o_found, o_exhausted, o_aborted, o_busy;
  logic [KW-1:0]  o_key_out, o_progress_key;
  logic [1:0]     o_winner_idx;
  logic [CW-1:0]  o_cycle_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string          name;
    int             found_cyc;
    logic [CC-1:0]  mask;
    int             abort_cyc;
    int             busy_low;
    logic           e_found;
    logic           e_exh;
    logic           e_abt;
    logic [1:0]     e_idx;
    logic [KW-1:0]  e_key;
    logic [CW-1:0]  e_cnt;
  } vec_t;

  vec_t vt [11];
  vec_t sb [$];

  assign core_key = {keys[3], keys[2], keys[1], keys[0]};

  always #5 clk = ~clk;

  key_search_coordinator #(.CORE_COUNT(CC), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .i_core_found(core_found), .i_core_busy(core_busy), .i_core_key(core_key),
    .o_core_start(o_core_start), .o_stop_all(o_stop_all), .o_found(o_found),
    .o_exhausted(o_exhausted), .o_aborted(o_aborted), .o_busy(o_busy),
    .o_key_out(o_key_out), .o_winner_idx(o_winner_idx),
    .o_progress_key(o_progress_key), .o_cycle_count(o_cycle_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " core_start"}, 32'(o_core_start), 0);
    check({tag, " stop_all"}, 32'(o_stop_all), 0);
    check({tag, " found"}, 32'(o_found), 0);
    check({tag, " exhausted"}, 32'(o_exhausted), 0);
    check({tag, " aborted"}, 32'(o_aborted), 0);
    check({tag, " busy"}, 32'(o_busy), 0);
    check({tag, " key_out"}, 32'(o_key_out), 0);
    check({tag, " winner_idx"}, 32'(o_winner_idx), 0);
    check({tag, " progress_key"}, 32'(o_progress_key), 0);
    check({tag, " cycle_count"}, 32'(o_cycle_count), 0);
  endtask

  // Returns at the negedge inside the LAUNCH cycle with start already dropped.
  task automatic do_launch(input string tag);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    check({tag, " launch core_start"}, 32'(o_core_start), 1);
    check({tag, " launch busy"}, 32'(o_busy), 1);
    check({tag, " launch stop_all"}, 32'(o_stop_all), 0);
    check({tag, " launch flags"}, 32'({o_found, o_exhausted, o_aborted}), 0);
    check({tag, " launch key_idx"}, 32'({o_key_out, o_winner_idx}), 0);
    check({tag, " launch cycle_count"}, 32'(o_cycle_count), 0);
    start = 1'b0;
  endtask

  task automatic run_vector(input vec_t v);
    vec_t e;
    int   k;
    bit   done;
    core_found = '0;
    abort      = 1'b0;
    core_busy  = (v.busy_low == 0) ? '0 : '1;
    do_launch(v.name);
    sb.push_back(v);
    @(negedge clk);
    check({v.name, " search1 core_start"}, 32'(o_core_start), 0);
    check({v.name, " search1 busy"}, 32'(o_busy), 1);
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      k++;
      core_found = (k == v.found_cyc) ? v.mask : '0;
      abort      = (k == v.abort_cyc);
      core_busy  = (k >= v.busy_low) ? '0 : '1;
      @(negedge clk);
      if (o_stop_all && o_busy) begin
        check({v.name, " latch winner_idx"}, 32'(o_winner_idx), 32'(v.e_idx));
        check({v.name, " latch found_low"}, 32'(o_found), 0);
      end
      if (o_found || o_exhausted || o_aborted) done = 1'b1;
    end
    core_found = '0;
    abort      = 1'b0;
    core_busy  = '1;
    check({v.name, " search_done"}, 32'(done), 1);
    e = sb.pop_front();
    check({e.name, " found"}, 32'(o_found), 32'(e.e_found));
    check({e.name, " exhausted"}, 32'(o_exhausted), 32'(e.e_exh));
    check({e.name, " aborted"}, 32'(o_aborted), 32'(e.e_abt));
    check({e.name, " winner_idx"}, 32'(o_winner_idx), 32'(e.e_idx));
    check({e.name, " key_out"}, 32'(o_key_out), 32'(e.e_key));
    check({e.name, " cycle_count"}, 32'(o_cycle_count), 32'(e.e_cnt));
    check({e.name, " stop_all"}, 32'(o_stop_all), 1);
    check({e.name, " busy"}, 32'(o_busy), 0);
  endtask

  initial begin
    keys[0] = 22'h0AAAA1;
    keys[1] = 22'h155555;
    keys[2] = 22'h01A2B3;
    keys[3] = 22'h3FFFFF;

    //          name                 fcyc mask     acyc blow  F  X  A  idx   key          cnt
    vt[0]  = '{"c2_cycle10",         10, 4'b0100, 99,  99,  1, 0, 0, 2'd2, 22'h01A2B3, 4'd10};
    vt[1]  = '{"c1c3_same",          4,  4'b1010, 99,  99,  1, 0, 0, 2'd1, 22'h155555, 4'd4};
    vt[2]  = '{"exhaust_grace",      99, 4'b0000, 99,  0,   0, 1, 0, 2'd0, 22'h000000, 4'd3};
    vt[3]  = '{"found_over_abort",   6,  4'b0001, 6,   99,  1, 0, 0, 2'd0, 22'h0AAAA1, 4'd6};
    vt[4]  = '{"abort_c5",           99, 4'b0000, 5,   99,  0, 0, 1, 2'd0, 22'h000000, 4'd5};
    vt[5]  = '{"found_over_exh",     7,  4'b1000, 99,  7,   1, 0, 0, 2'd3, 22'h3FFFFF, 4'd7};
    vt[6]  = '{"cnt_saturate",       20, 4'b0010, 99,  99,  1, 0, 0, 2'd1, 22'h155555, 4'd15};
    vt[7]  = '{"found_in_grace",     1,  4'b0001, 99,  0,   1, 0, 0, 2'd0, 22'h0AAAA1, 4'd1};
    vt[8]  = '{"exhaust_late",       99, 4'b0000, 99,  8,   0, 1, 0, 2'd0, 22'h000000, 4'd8};
    vt[9]  = '{"abort_c1",           99, 4'b0000, 1,   0,   0, 0, 1, 2'd0, 22'h000000, 4'd1};
    vt[10] = '{"c2c3_same",          2,  4'b1100, 99,  99,  1, 0, 0, 2'd2, 22'h01A2B3, 4'd2};

    // Reset state, with start asserted to show it has no effect.
    #1 rst = 1'b1;
    start = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    check_zero("reset_clocked");
    start = 1'b0;
    abort = 1'b1;
    rst   = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_abort busy", 32'(o_busy), 0);
      check("idle_abort stop_all", 32'(o_stop_all), 0);
    end
    abort = 1'b0;

    run_vector(vt[0]);

    // Start held high through DONE must not relaunch.
    start = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_start core_start", 32'(o_core_start), 0);
      check("hold_start found", 32'(o_found), 1);
    end

    run_vector(vt[1]);
    run_vector(vt[2]);

    // Abort in DONE is ignored, and blocks a launch while asserted.
    abort = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("done_abort exhausted", 32'(o_exhausted), 1);
      check("done_abort aborted", 32'(o_aborted), 0);
    end
    start = 1'b1;
    @(negedge clk);
    check("done_abort no_launch", 32'(o_core_start), 0);
    abort = 1'b0;

    for (int i = 3; i < 11; i++) run_vector(vt[i]);

    // Long search: counter saturates, progress is live, then async reset mid-SEARCH.
    core_found = '0;
    core_busy  = '1;
    do_launch("long");
    for (int m = 1; m <= 20; m++) begin
      @(negedge clk);
      if (m == 10) check("long cycle_count", 32'(o_cycle_count), 9);
      if (m >= 17) check("long cycle_count_sat", 32'(o_cycle_count), 15);
    end
    keys[0] = 22'h123456;
    #1 check("progress_live", 32'(o_progress_key), 32'h123456);
    keys[0] = 22'h0AAAA1;
    #1 rst = 1'b1;
    #1 check_zero("async_reset");
    start = 1'b1;
    @(negedge clk);
    check_zero("async_reset_held");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset core_start", 32'(o_core_start), 1);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("post_reset aborted", 32'(o_aborted), 1);
    check("post_reset cycle_count", 32'(o_cycle_count), 1);

    run_vector(vt[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
